// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle instruction sequencer driving PC/IR/register/memory strobes,
// with single-step, halt-at-boundary, illegal-opcode trap and a saturating retire counter.
module mc_sequencer #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [6:0]         opcode,
    input  logic               mem_ready,
    input  logic               step_en,
    input  logic               step_req,
    input  logic               halt_req,
    output logic               pc_load_entry,
    output logic               pc_we,
    output logic               ir_we,
    output logic               reg_we,
    output logic               mem_re,
    output logic               mem_we,
    output logic [2:0]         state,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);
    typedef enum logic [2:0] {IDLE, LOAD, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    typedef enum logic [2:0] {C_NONE, C_R, C_I, C_LW, C_S, C_B, C_JAL} cls_t;

    state_t             state_q, state_d;
    cls_t               cls_q, cls_d, dec_cls;
    logic               illegal_q, illegal_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               go, boundary;

    assign dec_cls = opcode == 7'b0110011 ? C_R   :
                     opcode == 7'b0010011 ? C_I   :
                     opcode == 7'b0000011 ? C_LW  :
                     opcode == 7'b0100011 ? C_S   :
                     opcode == 7'b1100011 ? C_B   :
                     opcode == 7'b1101111 ? C_JAL : C_NONE;

    // Strobes are decoded from the registered state, so reset clears them at once.
    assign go            = mem_ready && (!step_en || step_req);
    assign pc_load_entry = state_q == LOAD;
    assign ir_we         = state_q == FETCH && go;
    assign mem_re        = state_q == FETCH || (state_q == MEM && cls_q == C_LW);
    assign mem_we        = state_q == MEM && cls_q == C_S && mem_ready;
    assign reg_we        = state_q == WB;
    assign pc_we         = state_q == LOAD || state_q == WB || mem_we ||
                           (state_q == EXEC && cls_q == C_B);
    assign boundary      = pc_we && state_q != LOAD;

    assign state       = state_q;
    assign busy        = state_q != IDLE && state_q != HALT;
    assign halted      = state_q == HALT;
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE:    state_d = start ? LOAD : IDLE;
            LOAD:    state_d = FETCH;
            FETCH:   state_d = go ? DECODE : FETCH;
            DECODE: begin
                cls_d     = dec_cls;
                state_d   = dec_cls == C_NONE ? HALT : EXEC;
                illegal_d = illegal_q || dec_cls == C_NONE;
            end
            EXEC:    state_d = cls_q == C_B ? FETCH :
                               (cls_q == C_LW || cls_q == C_S) ? MEM : WB;
            MEM:     state_d = !mem_ready ? MEM : cls_q == C_LW ? WB : FETCH;
            WB:      state_d = FETCH;
            HALT: begin
                state_d   = start ? LOAD : HALT;
                illegal_d = start ? 1'b0 : illegal_q;
                cnt_d     = start ? '0 : cnt_q;
            end
            default: state_d = IDLE;
        endcase
        // Retirement overrides the per-state successor.
        if (boundary) begin
            cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
            state_d = halt_req ? HALT : FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cls_q     <= C_NONE;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameter: COUNT_W, default 16, width of the retired-instruction counter.
REQ-002 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: start  in  1  begin execution from entry_point; honoured only in IDLE or HALT.
REQ-005 Port: opcode  in  7  ins[6:0] from the fetched instruction register; valid from DECODE onward.
REQ-006 Port: mem_ready  in  1  instruction/data memory access complete this cycle.
REQ-007 Port: step_en  in  1  single-step mode enable.
REQ-008 Port: step_req  in  1  single-step go; level, sampled in FETCH.
REQ-009 Port: halt_req  in  1  stop at the next instruction boundary.
REQ-010 Port: pc_load_entry  out  1  PC takes entry_point (INT-style select).
REQ-011 Port: pc_we, ir_we, reg_we, mem_re, mem_we  out  1 each  datapath write/access strobes.
REQ-012 Port: state  out  3  IDLE=0 LOAD=1 FETCH=2 DECODE=3 EXEC=4 MEM=5 WB=6 HALT=7.
REQ-013 Port: busy, halted, illegal  out  1 each  status flags.
REQ-014 Port: instr_count  out  COUNT_W  retired-instruction count.

Function
REQ-015 Strobes SHALL be decoded from state (Moore), except where gated by mem_ready or step_req as stated below.
REQ-016 IDLE: start=1 SHALL move to LOAD; otherwise the block SHALL stay in IDLE.
REQ-017 LOAD: the block SHALL assert pc_load_entry and pc_we for exactly one cycle, then move to FETCH.
REQ-018 FETCH: mem_re=1; go = mem_ready && (!step_en || step_req).
REQ-019 FETCH exit: ir_we=1 only in the go cycle; the block SHALL move to DECODE on go and hold in FETCH otherwise.
REQ-020 DECODE: the block SHALL latch the opcode class: R=0110011, I=0010011, LW=0000011, S=0100011, B=1100011, JAL=1101111.
REQ-021 DECODE: any other opcode SHALL go to HALT with illegal=1; otherwise the block SHALL go to EXEC.
REQ-022 R, I and JAL SHALL follow EXEC->WB; in WB, reg_we=1 and pc_we=1 for one cycle.
REQ-023 LW SHALL follow EXEC->MEM->WB; MEM asserts mem_re and holds until mem_ready; WB asserts reg_we=1 and pc_we=1.
REQ-024 S SHALL follow EXEC->MEM; mem_we=1 and pc_we=1 only in the MEM cycle where mem_ready=1, then FETCH.
REQ-025 B SHALL assert pc_we=1 in EXEC (branch target or PC+4 selection is external), then go to FETCH.
REQ-026 The instruction boundary SHALL be the cycle in which pc_we=1, outside LOAD.
REQ-027 At the boundary: instr_count += 1, saturating at all-ones; next state = HALT if halt_req=1, else FETCH.
REQ-028 halt_req outside a boundary cycle SHALL be ignored (not latched).
REQ-029 HALT: halted=1 and all strobes 0; start=1 SHALL clear illegal, clear instr_count and go to LOAD.
REQ-030 start in LOAD through WB SHALL be ignored.
REQ-031 busy SHALL be 1 in states LOAD through WB, and 0 in IDLE and HALT.
REQ-032 illegal SHALL be sticky until reset or a start from HALT.
REQ-033 reg_we, mem_we and pc_we SHALL never be asserted for more than one cycle per instruction.
REQ-034 mem_re and mem_we SHALL never be asserted together.
REQ-035 Per-instruction latency with mem_ready=1: R/I/JAL/LW(no LW wait)=4 or 5 cycles (LW 5); S=4; B=3.

Reset
REQ-036 While reset=1, the block SHALL force state=IDLE, instr_count=0, illegal=0, latched class=0 and all outputs 0, asynchronously and mid-operation (e.g. mem_we drops immediately).
REQ-037 After reset deassertion, the block SHALL remain in IDLE until start=1.

Verification
REQ-038 Reset pulsed during MEM of a store with mem_ready=1 -> mem_we, pc_we and state drop to 0 the same cycle; instr_count=0.
REQ-039 start=1, opcode=0110011, mem_ready=1 -> states 1,2,3,4,6,2; reg_we and pc_we high only in WB; instr_count=1.
REQ-040 LW with mem_ready=0 for 3 MEM cycles -> mem_re high for 4 MEM cycles; reg_we high for 1 WB cycle; instr_count +1.
REQ-041 S with mem_ready late by 2 cycles -> mem_we high exactly 1 cycle, coincident with mem_ready; reg_we never high.
REQ-042 opcode=1111111 -> DECODE->HALT; illegal=1, halted=1, no pc_we; then start=1 -> LOAD with illegal=0.
REQ-043 step_en=1, step_req=0 for 5 cycles -> FETCH held, ir_we=0; step_req=1 -> ir_we pulse. halt_req=1 during B EXEC -> HALT next; halt_req=1 during DECODE only -> ignored.
